// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Owns the single write port (we3/wa3/wd3) of the register file.
//            Two writeback requesters compete for it. req0 is the ALU path and
//            req1 is the load path. Contended cycles are resolved round-robin.
//            A pending-write scoreboard lets issue/decode stall on registers
//            whose writes are still outstanding.
// Ports    : clk, reset (async, active-low)
//            req0_*/req1_* : valid/addr/data in, ready out (grant this cycle)
//            rsv_valid/rsv_addr : destination reservation from issue
//            qa1/qa2 -> busy1/busy2 : scoreboard queries (no bypass)
//            we3/wa3/wd3   : registered regfile write port
//            sb_err        : sticky scoreboard protocol error
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] qa1,
    input  logic [ADDR_W-1:0] qa2,
    output logic              busy1,
    output logic              busy2,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              sb_err
);

    localparam int              NREG  = 2 ** ADDR_W;
    localparam logic [NREG-1:0] C_ONE = {{(NREG-1){1'b0}}, 1'b1};

    // 1 means req1 won the most recent contended grant, so req0 wins the next tie.
    logic              r_last_grant;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_wr_en;

    logic              r_we3;
    logic [ADDR_W-1:0] r_wa3;
    logic [DATA_W-1:0] r_wd3;

    logic [NREG-1:0]   r_pending;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;
    logic              w_err_dup;
    logic              w_err_unrsv;
    logic              r_sb_err;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the side that
    // did not win the last tie is granted.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
        w_gnt1 = req1_valid & ~w_gnt0;
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_sel_addr = w_gnt0 ? req0_addr : req1_addr;
    assign w_sel_data = w_gnt0 ? req0_data : req1_data;

    // A write to register 0 is consumed but never reaches the regfile.
    assign w_wr_en = (w_gnt0 | w_gnt1) & (w_sel_addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (req0_valid && req1_valid) begin
            r_last_grant <= w_gnt1;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: one-cycle latency. wa3/wd3 only move when a real
    // write is issued so they hold across idle and register-0 cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_wr_en;
            if (w_wr_en) begin
                r_wa3 <= w_sel_addr;
                r_wd3 <= w_sel_data;
            end
        end
    end

    assign we3 = r_we3;
    assign wa3 = r_wa3;
    assign wd3 = r_wd3;

    // ------------------------------------------------------------------
    // Scoreboard. Set mask excludes register 0, so pending[0] never rises.
    // Set is applied after clear, so a re-reservation in the write cycle
    // leaves the bit set.
    // ------------------------------------------------------------------
    assign w_set_mask = (rsv_valid && (rsv_addr != '0)) ? (C_ONE << rsv_addr) : '0;
    assign w_clr_mask = r_we3 ? (C_ONE << r_wa3) : '0;

    assign w_err_dup   = rsv_valid & (rsv_addr != '0) & r_pending[rsv_addr]
                         & ~w_clr_mask[rsv_addr];
    assign w_err_unrsv = r_we3 & (r_wa3 != '0) & ~r_pending[r_wa3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_sb_err  <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            if (w_err_dup || w_err_unrsv) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    // No bypass: a register written this cycle still reads busy until the edge.
    assign busy1  = r_pending[qa1];
    assign busy2  = r_pending[qa2];
    assign sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed self-checking bench for rf_wb_arbiter. A reference
//            model predicts grants, scoreboard bits and sb_err; accepted
//            writes are queued and compared when they reach the write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] qa1;
    logic [ADDR_W-1:0] qa2;
    logic              busy1;
    logic              busy2;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic              sb_err;

    rf_wb_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .qa1        (qa1),
        .qa2        (qa2),
        .busy1      (busy1),
        .busy2      (busy2),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .sb_err     (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    logic        m_last;
    logic [31:0] m_pend;
    logic        m_err;
    logic        m_we;
    logic [4:0]  m_wa;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_pend = '0;
        m_err  = 1'b0;
        m_we   = 1'b0;
        m_wa   = '0;
        q.delete();
    endtask

    // One clock cycle: starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic rv, input logic [4:0] ra);
        logic g0;
        logic g1;
        wr_t  e;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rsv_valid  = rv; rsv_addr  = ra;
        #1;
        g0 = v0 && (!v1 || m_last);
        g1 = v1 && !g0;
        check("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
        check("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
        if (v0 && v1) m_last = g1;
        if (rv && ra != 0 && m_pend[ra] && !(m_we && m_wa == ra)) m_err = 1'b1;
        if (m_we && m_wa != 0 && !m_pend[m_wa]) m_err = 1'b1;
        if (m_we) m_pend[m_wa] = 1'b0;
        if (rv && ra != 0) m_pend[ra] = 1'b1;
        if (g0 && a0 != 0) q.push_back({a0, d0});
        if (g1 && a1 != 0) q.push_back({a1, d1});
        @(posedge clk); #1;
        if (q.size() > 0) begin
            e    = q.pop_front();
            m_we = 1'b1;
            m_wa = e.a;
            check("we3", {31'b0, we3}, 32'd1);
            check("wa3", {27'b0, wa3}, {27'b0, e.a});
            check("wd3", wd3, e.d);
        end else begin
            m_we = 1'b0;
            check("we3_idle", {31'b0, we3}, 32'd0);
        end
        check("sb_err", {31'b0, sb_err}, {31'b0, m_err});
        check("busy1", {31'b0, busy1}, {31'b0, m_pend[qa1]});
        check("busy2", {31'b0, busy2}, {31'b0, m_pend[qa2]});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset      = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1234;
        req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
        rsv_valid  = 1'b0; rsv_addr  = '0;
        qa1        = 5'd3; qa2 = 5'd0;
        model_reset();

        // Reset held with a request present
        repeat (2) @(posedge clk);
        #1;
        check("rst_we3",    {31'b0, we3},    32'd0);
        check("rst_wa3",    {27'b0, wa3},    32'd0);
        check("rst_wd3",    wd3,             32'd0);
        check("rst_busy1",  {31'b0, busy1},  32'd0);
        check("rst_busy2",  {31'b0, busy2},  32'd0);
        check("rst_sb_err", {31'b0, sb_err}, 32'd0);
        reset = 1'b1;

        // Contention: first tie goes to req0, then alternates
        qa1 = 5'd6; qa2 = 5'd7;
        cycle(0, 0, 0,          0, 0, 0,          1, 5'd6);
        cycle(0, 0, 0,          0, 0, 0,          1, 5'd7);
        cycle(1, 5'd6, 32'd100, 1, 5'd7, 32'd200, 0, 0);
        cycle(1, 5'd6, 32'd101, 1, 5'd7, 32'd200, 1, 5'd6);
        cycle(1, 5'd6, 32'd101, 1, 5'd7, 32'd201, 1, 5'd7);
        cycle(1, 5'd6, 32'd102, 1, 5'd7, 32'd201, 1, 5'd6);
        idle();
        idle();

        // Single write with busy tracking
        qa1 = 5'd5; qa2 = 5'd0;
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd5);
        cycle(1, 5'd5, 32'h0000_00AA, 0, 0, 0, 0, 0);
        idle();

        // Register 0: consumed with no write; reservation of r0 ignored
        cycle(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0);
        idle();

        // Same-cycle set/clear then duplicate reservation
        qa1 = 5'd9;
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd9);
        cycle(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd9);
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd9);
        idle();

        // Write in flight, then asynchronous reset mid-stream
        cycle(1, 5'd9, 32'h9A, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_we3",    {31'b0, we3},    32'd0);
        check("mid_rst_wa3",    {27'b0, wa3},    32'd0);
        check("mid_rst_sb_err", {31'b0, sb_err}, 32'd0);
        check("mid_rst_busy1",  {31'b0, busy1},  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Unreserved write flags sb_err one cycle after the write cycle
        qa1 = 5'd12;
        cycle(1, 5'd12, 32'hC0DE, 0, 0, 0, 0, 0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the 32x32 register file.
- Arbitrates between two writeback requesters: req0 is the ALU result path, req1 is the memory-load path.
- Keeps a pending-write scoreboard so that issue/decode can stall on registers whose writes are still outstanding.
- Sits between the multicycle datapath writeback sources and the regfile write port.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address; 2**ADDR_W registers.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a write.
- req0_addr  input  ADDR_W  requester 0 destination register.
- req0_data  input  DATA_W  requester 0 data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid  input  1  requester 1 has a write.
- req1_addr  input  ADDR_W  requester 1 destination register.
- req1_data  input  DATA_W  requester 1 data.
- req1_ready  output  1  requester 1 write accepted this cycle.
- rsv_valid  input  1  issue stage reserves a destination register.
- rsv_addr  input  ADDR_W  register being reserved.
- qa1, qa2  input  ADDR_W  scoreboard query addresses.
- busy1, busy2  output  1  pending bit of qa1/qa2; 0 for address 0.
- we3  output  1  regfile write enable (registered).
- wa3  output  ADDR_W  regfile write address (registered).
- wd3  output  DATA_W  regfile write data (registered).
- sb_err  output  1  sticky scoreboard protocol error.

Behaviour:
- Reset (reset=0, asynchronous): we3=0, wa3=0, wd3=0, sb_err=0, all pending bits=0, last_grant=1 (req0 wins the first tie).
- Arbitration (combinational, same cycle):
  - At most one grant per cycle. readyN is 1 only for the granted requester.
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted; last_grant then updates to the winner (round-robin, no starvation).
  - last_grant updates only on a grant made while both requesters are valid.
- Handshake:
  - A transfer occurs when validN & readyN at the rising edge.
  - The requester holds valid, addr and data stable until ready is seen.
  - valid must not depend on ready.
- Output stage:
  - An accepted write appears on wa3/wd3 with we3=1 in the next cycle: latency 1, throughput 1 per cycle.
  - With no accept, we3=0 next cycle; wa3/wd3 hold their last values.
  - An accepted write to address 0 is consumed (ready=1) but produces we3=0.
- Scoreboard:
  - pending[r] is set at the edge where rsv_valid=1 and rsv_addr=r, for r≠0.
  - pending[r] is cleared at the edge ending the cycle where we3=1 and wa3=r.
  - Set and clear to the same r in the same cycle: set wins, so pending stays 1 (new reservation).
  - pending[0] is always 0.
  - busyN = pending[qaN], combinational, no bypass. A register being written this cycle still reads busy=1 until the next edge.
- sb_err is set (sticky until reset) on either condition:
  - rsv_valid to a register that is already pending and not being cleared this cycle.
  - we3=1 to a nonzero wa3 whose pending bit is 0.
- No backpressure from the regfile: the port is always free, so a valid request is never refused except by the arbitration loss.
- Reset asserted mid-operation: the in-flight output write is dropped (we3=0 immediately) and all pending bits clear.

Test Plan:
- Reset: hold reset=0 with req0_valid=1 -> we3=0, busy1=busy2=0, sb_err=0, req0_ready is don't-care. Release reset -> first grant to req0.
- Single write: rsv r5; req0 addr=5 data=0x0000_00AA -> req0_ready=1 in cycle t; at t+1 we3=1, wa3=5, wd3=0xAA, busy(qa=5)=1; at t+2 busy=0.
- Contention: both valid every cycle (req0→r6, req1→r7, all reserved) -> grants alternate 0,1,0,1; we3 stays high continuously; each data value written exactly once.
- Address 0: req1 addr=0 data=0xFFFF_FFFF -> req1_ready=1, we3 stays 0 next cycle, sb_err=0.
- Same-cycle set/clear: we3 writing r9 while rsv_valid to r9 -> pending[9]=1 afterwards, sb_err=0. Reserving r9 again before its write -> sb_err=1 and it stays 1.
- Unreserved write: req0 addr=12 with no reservation -> one cycle after the we3 cycle, sb_err=1. Reset mid-stream -> we3=0 at once, sb_err=0.
